jtcontra_muldiv_arb: RTL

JTCONTRA_MULDIV_ARB -- requirements
Module: jtcontra_muldiv_arb

---
 rtl/jtcontra_muldiv_arb_if.sv | 44 ++++
 rtl/jtcontra_muldiv_arb.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/jtcontra_muldiv_arb_if.sv
// Requester ports and 007452 bus for the two-port multiply/divide arbiter.
// slave is the arbiter side; master is the requesters plus the 007452.
interface jtcontra_muldiv_arb_if;
    logic        req0;
    logic        req1;
    logic        op0;
    logic        op1;
    logic [15:0] opa0;
    logic [15:0] opa1;
    logic [15:0] opb0;
    logic [15:0] opb1;
    logic        ack0;
    logic        ack1;
    logic [15:0] res_lo0;
    logic [15:0] res_lo1;
    logic [15:0] res_hi0;
    logic [15:0] res_hi1;
    logic        busy;
    logic        mdu_cs;
    logic        mdu_wrn;
    logic [2:0]  mdu_addr;
    logic [7:0]  mdu_dout;
    logic [7:0]  mdu_din;

    modport slave (
        input  req0, req1, op0, op1,
        input  opa0, opa1, opb0, opb1,
        input  mdu_din,
        output ack0, ack1,
        output res_lo0, res_lo1, res_hi0, res_hi1,
        output busy,
        output mdu_cs, mdu_wrn, mdu_addr, mdu_dout
    );

    modport master (
        output req0, req1, op0, op1,
        output opa0, opa1, opb0, opb1,
        output mdu_din,
        input  ack0, ack1,
        input  res_lo0, res_lo1, res_hi0, res_hi1,
        input  busy,
        input  mdu_cs, mdu_wrn, mdu_addr, mdu_dout
    );
endinterface

// File: rtl/jtcontra_muldiv_arb.sv
// Round-robin arbiter sharing one 007452 multiplier/divider between two ports.
// Operands are written, the chip is given its settle time, then results are read.
module jtcontra_muldiv_arb #(
    parameter int MUL_WAIT = 2,
    parameter int DIV_WAIT = 20
) (
    input  logic                       clk,
    input  logic                       rst_n,
    jtcontra_muldiv_arb_if.slave       bus
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WAIT,
        RD,
        DONE
    } state_t;

    state_t      st;
    state_t      st_nx;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nx;
    logic [1:0]  beat;
    logic [1:0]  beat_nx;
    logic        gnt;
    logic        gnt_nx;
    logic        lat;
    logic        rd_en;
    logic        fin;
    logic [1:0]  last_beat;

    logic        op;
    logic [15:0] opa;
    logic [15:0] opb;
    logic [31:0] res;
    logic [31:0] res_nx;

    logic [15:0] lo0;
    logic [15:0] lo1;
    logic [15:0] hi0;
    logic [15:0] hi1;

    logic        cs;
    logic        wrn;
    logic [2:0]  addr;
    logic [7:0]  dout;

    assign last_beat = op ? 2'd3 : 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= IDLE;
            cnt  <= 8'd0;
            beat <= 2'd0;
            // port 1 counts as last granted, so port 0 wins first
            gnt  <= 1'b1;
        end else begin
            st   <= st_nx;
            cnt  <= cnt_nx;
            beat <= beat_nx;
            gnt  <= gnt_nx;
        end
    end

    always_comb begin
        st_nx   = st;
        cnt_nx  = cnt;
        beat_nx = beat;
        gnt_nx  = gnt;
        lat     = 1'b0;
        rd_en   = 1'b0;
        fin     = 1'b0;
        cs      = 1'b0;
        wrn     = 1'b1;
        addr    = 3'd0;
        dout    = 8'd0;
        unique case (st)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    unique case (1'b1)
                        bus.req0 && bus.req1:  gnt_nx = ~gnt;
                        bus.req1 && !bus.req0: gnt_nx = 1'b1;
                        default:               gnt_nx = 1'b0;
                    endcase
                    lat     = 1'b1;
                    beat_nx = 2'd0;
                    st_nx   = WR;
                end
            end
            WR: begin
                cs  = 1'b1;
                wrn = 1'b0;
                if (!op) begin
                    addr = {2'b00, beat[0]};
                    dout = beat[0] ? opb[7:0] : {1'b0, opa[6:0]};
                end else begin
                    unique case (beat)
                        2'd0: begin addr = 3'd2; dout = opb[15:8]; end
                        2'd1: begin addr = 3'd3; dout = opb[7:0];  end
                        2'd2: begin addr = 3'd4; dout = opa[15:8]; end
                        default: begin addr = 3'd5; dout = opa[7:0]; end
                    endcase
                end
                if (beat == last_beat) begin
                    beat_nx = 2'd0;
                    cnt_nx  = op ? 8'(DIV_WAIT - 1) : 8'(MUL_WAIT - 1);
                    st_nx   = WAIT;
                end else begin
                    beat_nx = beat + 2'd1;
                end
            end
            WAIT: begin
                if (cnt == 8'd0) begin
                    st_nx = RD;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            RD: begin
                cs    = 1'b1;
                rd_en = 1'b1;
                if (!op) begin
                    addr = {2'b00, beat[0]};
                end else begin
                    unique case (beat)
                        2'd0:    addr = 3'd4;
                        2'd1:    addr = 3'd5;
                        2'd2:    addr = 3'd2;
                        default: addr = 3'd3;
                    endcase
                end
                if (beat == last_beat) begin
                    beat_nx = 2'd0;
                    fin     = 1'b1;
                    st_nx   = DONE;
                end else begin
                    beat_nx = beat + 2'd1;
                end
            end
            DONE: begin
                st_nx = IDLE;
            end
            default: begin
                st_nx = IDLE;
            end
        endcase
    end

    // Read beats map to result bytes in order: lo[7:0], lo[15:8], hi[7:0], hi[15:8]
    always_comb begin
        res_nx = res;
        unique case (beat)
            2'd0:    res_nx[7:0]   = bus.mdu_din;
            2'd1:    res_nx[15:8]  = bus.mdu_din;
            2'd2:    res_nx[23:16] = bus.mdu_din;
            default: res_nx[31:24] = bus.mdu_din;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op  <= 1'b0;
            opa <= 16'd0;
            opb <= 16'd0;
            res <= 32'd0;
            lo0 <= 16'd0;
            lo1 <= 16'd0;
            hi0 <= 16'd0;
            hi1 <= 16'd0;
        end else begin
            if (lat) begin
                op  <= gnt_nx ? bus.op1  : bus.op0;
                opa <= gnt_nx ? bus.opa1 : bus.opa0;
                opb <= gnt_nx ? bus.opb1 : bus.opb0;
                res <= 32'd0;
            end
            if (rd_en) begin
                res <= res_nx;
            end
            // Port outputs load on the last read edge so they are valid with ack
            if (fin) begin
                if (gnt) begin
                    lo1 <= res_nx[15:0];
                    hi1 <= res_nx[31:16];
                end else begin
                    lo0 <= res_nx[15:0];
                    hi0 <= res_nx[31:16];
                end
            end
        end
    end

    assign bus.ack0     = (st == DONE) && !gnt;
    assign bus.ack1     = (st == DONE) && gnt;
    assign bus.res_lo0  = lo0;
    assign bus.res_lo1  = lo1;
    assign bus.res_hi0  = hi0;
    assign bus.res_hi1  = hi1;
    assign bus.busy     = (st != IDLE);
    assign bus.mdu_cs   = cs;
    assign bus.mdu_wrn  = wrn;
    assign bus.mdu_addr = addr;
    assign bus.mdu_dout = dout;

endmodule
